decode_hazard_ctrl: RTL
=======================

Name: decode_hazard_ctrl

Overview:
- Scoreboard-based issue controller for the decode stage.
- Tracks in-flight writes to each of the 8 architectural registers.
- Stalls the instruction in IF/ID while either of its register-file read ports would return stale data, or while its destination register's in-flight count is saturated.
- Counts writebacks retiring through the bypassing register file, so a same-cycle writeback to a source register clears the hazard.

Parameters:
- NUM_REGS, 8, number of architectural registers; selects are 3 bits.
- CNT_W, 2, width of each per-register in-flight counter.
- MAX_INFLIGHT, 3, maximum outstanding writes per register; must be <= 2**CNT_W-1.
- STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_rd1_use  in  1  instruction reads port 1 (instr[10:8]).
- id_rd1_sel  in  3  read port 1 register select.
- id_rd2_use  in  1  instruction reads port 2 (instr[7:5]).
- id_rd2_sel  in  3  read port 2 register select.
- id_wr_en  in  1  instruction writes a register.
- id_wr_sel  in  3  destination select, post-RegDst mux.
- wb_valid  in  1  writeback stage is writing the register file this cycle.
- wb_sel  in  3  writeback destination select.
- flush  in  1  full pipeline squash; all in-flight instructions are discarded.
- issue  out  1  instruction in IF/ID advances to ID/EX this cycle.
- stall  out  1  id_valid & ~issue & ~flush; holds PC and IF/ID.
- busy_mask  out  8  bit r set when cnt[r] != 0 (registered state).
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall=1.
- err  out  1  sticky; writeback to a register with no outstanding write.

Behaviour:
Reset (rst=0, asynchronous):
- All cnt[r] = 0.
- busy_mask = 0.
- stall_cycles = 0.
- err = 0.
- Combinational outputs (issue, stall) are forced to 0 during reset.

Per-register release term:
- rel[r] = wb_valid & (wb_sel == r) & ~flush.

RAW hazard, per read port p (1 or 2):
- haz_p = rdp_use & (cnt[rdp_sel] - rel[rdp_sel] != 0).
- A writeback retiring the last outstanding write in the same cycle is not a hazard; rf_bypass forwards the data.

WAW / capacity hazard:
- haz_w = id_wr_en & (cnt[id_wr_sel] - rel[id_wr_sel] == MAX_INFLIGHT).

Issue and stall (combinational, zero latency from current state and inputs):
- issue = id_valid & ~flush & ~haz_1 & ~haz_2 & ~haz_w.
- stall = id_valid & ~flush & ~issue.

Counter update, for each r, applied at the clock edge:
- acq[r] = issue & id_wr_en & (id_wr_sel == r).
- cnt[r] <= cnt[r] + acq[r] - rel[r]; acquire and release of the same register in one cycle leave cnt unchanged.
- Underflow: rel[r]=1 with cnt[r]=0 and acq[r]=0 sets err=1; cnt[r] stays 0.
- err clears only on reset.
- Overflow cannot occur because haz_w blocks issue at MAX_INFLIGHT.

Flush:
- On flush=1, all cnt[r] <= 0 at the next edge.
- issue=0 and stall=0 in the flush cycle.
- wb_valid in the flush cycle is ignored for scoreboard purposes; no err is raised.

busy_mask:
- Bit r = (cnt[r] != 0).
- Reflects registered state; not bypassed by the same-cycle writeback.

stall_cycles:
- Increments by 1 on each edge where stall=1.
- Saturates at all-ones.

No internal FSM beyond the counters. Single-cycle decision, so no multi-cycle handshake state; an instruction stalled in IF/ID is re-evaluated every cycle.

Test Plan:
1. Reset, then id_valid=1 reading r3/r4, no writer -> issue=1, stall=0, busy_mask=0x00.
2. Issue writer to r2 (id_wr_en=1, id_wr_sel=2). Next cycle, reader of r2 on port 1 -> stall=1, busy_mask=0x04. Hold 3 cycles, then wb_valid=1, wb_sel=2 in the 4th cycle -> issue=1 that same cycle, busy_mask=0x00 after the edge, stall_cycles=3.
3. Three back-to-back writers to r5 with no writeback -> third issues and cnt[5]=3; fourth writer to r5 -> stall=1. Then wb_sel=5 the same cycle the fourth presents -> issue=1, cnt[5] stays 3.
4. wb_valid=1, wb_sel=6 with cnt[6]=0 -> err=1 next edge and stays 1. cnt[6]=0. A following reader of r6 -> issue=1.
5. busy_mask=0x26 with a stalled reader. Assert flush for one cycle -> issue=0, stall=0, busy_mask=0x00 next edge. The stalled reader re-presented issues immediately.
6. Assert rst low mid-stall with cnt[1]=2 -> busy_mask=0, stall_cycles=0, err=0, issue=0 asynchronously. After release, a reader of r1 issues.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl -- scoreboard issue controller for the decode stage.
//
// Tracks the number of in-flight writes to each architectural register and
// decides, combinationally, whether the instruction held in IF/ID may issue.
// A writeback retiring through the bypassing register file in the same cycle
// is credited before the hazard check, so it clears a RAW hazard immediately.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   id_valid          IF/ID holds a valid instruction
//   id_rd1_use/_sel   read port 1 in use / register select
//   id_rd2_use/_sel   read port 2 in use / register select
//   id_wr_en/_sel     instruction writes a register / destination select
//   wb_valid/wb_sel   writeback stage writing the register file this cycle
//   flush             full pipeline squash
//   issue             instruction advances to ID/EX this cycle
//   stall             hold PC and IF/ID
//   busy_mask         bit r set while register r has outstanding writes
//   stall_cycles      saturating count of stalled cycles
//   err               sticky: writeback to a register with nothing outstanding

// Per-register in-flight write counter.
module decode_hazard_slot #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             acq,
    input  logic             rel,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    // rel is already masked by flush, so a squashed writeback never flags.
    assign underflow = rel & ~acq & (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         cnt <= '0;
        else if (flush)                   cnt <= '0;
        else if (acq & ~rel)              cnt <= cnt + CNT_W'(1);
        else if (rel & ~acq & cnt != '0)  cnt <= cnt - CNT_W'(1);
    end
endmodule

module decode_hazard_ctrl #(
    parameter int NUM_REGS     = 8,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_rd1_use,
    input  logic [2:0]             id_rd1_sel,
    input  logic                   id_rd2_use,
    input  logic [2:0]             id_rd2_sel,
    input  logic                   id_wr_en,
    input  logic [2:0]             id_wr_sel,
    input  logic                   wb_valid,
    input  logic [2:0]             wb_sel,
    input  logic                   flush,
    output logic                   issue,
    output logic                   stall,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   err
);
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            rel;
    logic [NUM_REGS-1:0]            acq;
    logic [NUM_REGS-1:0]            underflow;

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_reg
            assign rel[r]       = wb_valid & (wb_sel == 3'(r)) & ~flush;
            assign acq[r]       = issue & id_wr_en & (id_wr_sel == 3'(r));
            assign busy_mask[r] = (cnt[r] != '0);

            decode_hazard_slot #(.CNT_W(CNT_W)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .acq       (acq[r]),
                .rel       (rel[r]),
                .cnt       (cnt[r]),
                .underflow (underflow[r])
            );
        end
    endgenerate

    // Effective counts after crediting the same-cycle writeback. One extra
    // bit keeps a stray release on an idle register from aliasing to a
    // legal count (0 - 1 must neither read as 0 nor as MAX_INFLIGHT).
    logic [CNT_W:0] eff1, eff2, effw;
    logic           haz_1, haz_2, haz_w;

    assign eff1  = {1'b0, cnt[id_rd1_sel]} - (CNT_W+1)'(rel[id_rd1_sel]);
    assign eff2  = {1'b0, cnt[id_rd2_sel]} - (CNT_W+1)'(rel[id_rd2_sel]);
    assign effw  = {1'b0, cnt[id_wr_sel]}  - (CNT_W+1)'(rel[id_wr_sel]);

    assign haz_1 = id_rd1_use & (eff1 != '0);
    assign haz_2 = id_rd2_use & (eff2 != '0);
    assign haz_w = id_wr_en   & (effw == (CNT_W+1)'(MAX_INFLIGHT));

    // rst gates the decision so nothing issues while the scoreboard is held.
    assign issue = rst & id_valid & ~flush & ~haz_1 & ~haz_2 & ~haz_w;
    assign stall = rst & id_valid & ~flush & ~issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            err          <= 1'b0;
        end else begin
            if (stall && !(&stall_cycles))
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            if (|underflow)
                err <= 1'b1;
        end
    end
endmodule
